instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Parametrised instruction-memory loader that accepts batches of up to MAX_WORDS instruction words over a valid/ready handshake. It writes each batch sequentially, one word per cycle, into an internal word-addressed RAM at an append cursor. It rejects batches that would overflow the memory, with no partial write, and provides a registered read port for the fetch side. It sits between the instruction decoder/assembler front end and the instruction fetch stage.

## Interface
- WORD_W, 32, instruction word width in bits
- DEPTH, 1024, RAM depth in words (power of two, ≥ MAX_WORDS)
- MAX_WORDS, 6, maximum words per batch (≥ 1)
- ADDR_W, $clog2(DEPTH), RAM address width (derived)
- CNT_W, $clog2(MAX_WORDS+1), batch count width (derived)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- clear  in  1  synchronous soft clear: fill to 0, abort any batch in progress
- in_valid  in  1  batch offered
- in_ready  out  1  loader can accept a batch
- in_words  in  MAX_WORDS*WORD_W  batch payload; word k at [k*WORD_W +: WORD_W]
- in_count  in  CNT_W  number of valid words in batch
- rd_addr  in  ADDR_W  read address
- rd_data  out  WORD_W  registered read data
- fill  out  ADDR_W+1  words written since reset/clear (next write address)
- full  out  1  fill == DEPTH
- batch_done  out  1  one-cycle pulse: last word of a batch written
- err_count  out  1  one-cycle pulse: batch rejected, in_count == 0 or > MAX_WORDS
- err_overflow  out  1  one-cycle pulse: batch rejected, fill + in_count > DEPTH

## Operation
- States: IDLE, WRITE.
- in_ready = (state == IDLE) & ~clear. It is combinational from state and clear.
- Accept occurs on the edge where in_valid & in_ready.
- Accept with a count error (in_count == 0 or > MAX_WORDS): no write, stay IDLE, err_count pulses.
- Else accept with fill + in_count > DEPTH: no write, stay IDLE, err_overflow pulses. The count check has priority over the overflow check.
- Else accept: latch in_words and in_count, clear the word index, and go to WRITE.
- WRITE, each cycle:
  - ram[fill[ADDR_W-1:0]] <= word[index]; fill += 1; index += 1.
  - On the write of word in_count-1, return to IDLE and assert batch_done.
- The fill comparison uses ADDR_W+1 bits, so there is no wrap. A batch that exactly fills the RAM is legal, and full asserts after its last write. While full, every non-empty batch is rejected with err_overflow.
- clear in any state: fill <= 0, state <= IDLE, and the latched batch is discarded. The current cycle's write does not occur. clear wins over a simultaneous in_valid, and in_ready is 0 in that cycle. clear does not erase RAM contents.
- Read port: rd_data <= ram[rd_addr] every cycle. Read-during-write to the same address returns the old contents.
- Holding rst mid-batch aborts the batch. Words already written remain in RAM.

## Timing
- Reset values: state IDLE, fill 0, full 0, rd_data 0, batch_done 0, err_count 0, err_overflow 0, in_ready 1 once rst is released.
- Batch of n words accepted at edge T: word k is written at edge T+1+k. fill is visible as old+k+1 after that edge.
- in_ready is 0 from after edge T until after edge T+n. The earliest next accept is edge T+n+1, so one batch completes every n+1 cycles.
- batch_done is high during the cycle following edge T+n.
- err_count and err_overflow are high during the cycle following the rejecting edge. in_ready stays 1, so a rejected batch can be followed by a new one on the next edge.
- rd_data latency is 1 cycle from rd_addr.
- rst is asynchronous assert. All other behaviour is synchronous to clk.

## Test plan
- Reset, then batch count=2 with words 0xA0000001, 0xA0000002 -> in_ready low for 2 cycles; fill 0→1→2; batch_done once; reads of addr 0 and 1 return those words.
- Back-to-back batches with counts 6 then 3 -> second accepted exactly 7 cycles after the first; fill=9; ram[6..8] hold batch-2 words 0..2.
- count=0 and count=7 (MAX_WORDS=6) -> err_count pulses each time; fill unchanged; no RAM change.
- DEPTH=8: batches of 6 then 3 -> second gets err_overflow with fill stays 6; a following count=2 is accepted, fill=8, full=1; then count=1 gets err_overflow.
- clear asserted on the second WRITE cycle of a 5-word batch -> only word 0 written; fill=0; state IDLE; next batch overwrites addr 0.
- rst asserted mid-batch (count=4, after 2 writes) -> outputs return to reset values asynchronously; ram[0..1] retain data; ram[2..3] untouched.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: accepts batches of up to MAX_WORDS words, appends
// them one per cycle into an internal RAM, and serves a registered fetch read port.
module instr_mem_loader #(
   parameter int WORD_W    = 32,
   parameter int DEPTH     = 1024,
   parameter int MAX_WORDS = 6,
   parameter int ADDR_W    = $clog2(DEPTH),
   parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [MAX_WORDS*WORD_W-1:0] in_words,
   input  logic [CNT_W-1:0]            in_count,
   input  logic [ADDR_W-1:0]           rd_addr,
   output logic [WORD_W-1:0]           rd_data,
   output logic [ADDR_W:0]             fill,
   output logic                        full,
   output logic                        batch_done,
   output logic                        err_count,
   output logic                        err_overflow,
   output logic                        state_dbg
);

   // Handshake: a batch transfers on the rising edge where in_valid & in_ready;
   // the producer holds in_words/in_count stable while in_valid is high and
   // in_ready is low. in_ready is combinational from the FSM state and clear.

   typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

   state_t                      state_q, state_d;
   logic [ADDR_W:0]             fill_q, fill_d;
   logic [CNT_W-1:0]            idx_q, idx_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [MAX_WORDS*WORD_W-1:0] words_q, words_d;
   logic                        batch_done_q, batch_done_d;
   logic                        err_count_q, err_count_d;
   logic                        err_overflow_q, err_overflow_d;
   logic [WORD_W-1:0]           rd_data_q, rd_data_d;

   logic [WORD_W-1:0]           mem_q [DEPTH];
   logic                        wr_en;
   logic [WORD_W-1:0]           wr_data;
   logic                        count_bad;
   logic                        overflow;
   logic                        idx_last;
   logic [ADDR_W+1:0]           fill_sum;

   // One extra bit on the sum so fill + in_count never wraps before the compare.
   assign fill_sum  = (ADDR_W+2)'(fill_q) + (ADDR_W+2)'(in_count);
   assign overflow  = fill_sum > (ADDR_W+2)'(DEPTH);
   assign count_bad = (in_count == '0) || (in_count > CNT_W'(MAX_WORDS));
   assign idx_last  = (idx_q + 1'b1) == cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         fill_q         <= '0;
         idx_q          <= '0;
         cnt_q          <= '0;
         words_q        <= '0;
         batch_done_q   <= 1'b0;
         err_count_q    <= 1'b0;
         err_overflow_q <= 1'b0;
         rd_data_q      <= '0;
      end else begin
         state_q        <= state_d;
         fill_q         <= fill_d;
         idx_q          <= idx_d;
         cnt_q          <= cnt_d;
         words_q        <= words_d;
         batch_done_q   <= batch_done_d;
         err_count_q    <= err_count_d;
         err_overflow_q <= err_overflow_d;
         rd_data_q      <= rd_data_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      fill_d         = fill_q;
      idx_d          = idx_q;
      cnt_d          = cnt_q;
      words_d        = words_q;
      batch_done_d   = 1'b0;
      err_count_d    = 1'b0;
      err_overflow_d = 1'b0;
      if (clear) begin
         state_d = S_IDLE;
         fill_d  = '0;
         idx_d   = '0;
      end else if (state_q == S_WRITE) begin
         fill_d = fill_q + 1'b1;
         idx_d  = idx_q + 1'b1;
         if (idx_last) begin
            state_d      = S_IDLE;
            batch_done_d = 1'b1;
         end
      end else if (in_valid) begin
         // Count errors take precedence over the overflow check.
         if (count_bad) begin
            err_count_d = 1'b1;
         end else if (overflow) begin
            err_overflow_d = 1'b1;
         end else begin
            words_d = in_words;
            cnt_d   = in_count;
            idx_d   = '0;
            state_d = S_WRITE;
         end
      end
   end

   always_comb begin
      in_ready = (state_q == S_IDLE) && !clear;
      wr_en    = (state_q == S_WRITE) && !clear;
      wr_data  = '0;
      for (int k = 0; k < MAX_WORDS; k++) begin
         if (idx_q == CNT_W'(k)) wr_data = words_q[k*WORD_W +: WORD_W];
      end
   end

   // RAM has no reset; a read of the address being written returns old data.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[fill_q[ADDR_W-1:0]] <= wr_data;
   end

   assign rd_data_d    = mem_q[rd_addr];
   assign rd_data      = rd_data_q;
   assign fill         = fill_q;
   assign full         = fill_q == (ADDR_W+1)'(DEPTH);
   assign batch_done   = batch_done_q;
   assign err_count    = err_count_q;
   assign err_overflow = err_overflow_q;
   assign state_dbg    = (state_q == S_WRITE);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: constant vector table, directed corner sequences,
// and random traffic checked against a queue-based write model.
module tb_instr_mem_loader;
   localparam int W  = 32;
   localparam int D  = 16;
   localparam int MW = 6;
   localparam int AW = 4;
   localparam int CW = 3;

   logic           clk = 1'b0;
   logic           rst, clear, in_valid, in_ready;
   logic [MW*W-1:0] in_words;
   logic [CW-1:0]  in_count;
   logic [AW-1:0]  rd_addr;
   logic [W-1:0]   rd_data;
   logic [AW:0]    fill;
   logic           full, batch_done, err_count, err_overflow, state_dbg;

   instr_mem_loader #(.WORD_W(W), .DEPTH(D), .MAX_WORDS(MW)) dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_words(in_words), .in_count(in_count), .rd_addr(rd_addr), .rd_data(rd_data),
      .fill(fill), .full(full), .batch_done(batch_done), .err_count(err_count),
      .err_overflow(err_overflow), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // reference model: RAM image plus a queue of pending word writes
   typedef struct { int addr; logic [W-1:0] data; bit last; } pend_t;
   pend_t        pend_q[$];
   logic [W-1:0] m_mem [D];
   bit           m_valid [D];
   int           m_fill;
   logic [W-1:0] exp_q[$];

   int checks = 0;
   int errors = 0;

   bit           obs_ready, obs_done, obs_ec, obs_eo, obs_full;
   int           obs_fill;
   logic [W-1:0] obs_rd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [MW*W-1:0] rand_words();
      logic [MW*W-1:0] w;
      for (int k = 0; k < MW; k++) w[k*W +: W] = $urandom;
      return w;
   endfunction

   // driver: one clock of stimulus, model update and compare
   task automatic step(input bit v, input logic [MW*W-1:0] w, input int cnt,
                       input bit clr, input int ra);
      bit e_ready, e_done, e_ec, e_eo, rd_chk;
      pend_t p;
      @(negedge clk);
      in_valid = v; in_words = w; in_count = CW'(cnt); clear = clr; rd_addr = AW'(ra);
      #1;
      e_ready   = (pend_q.size() == 0) && !clr;
      obs_ready = in_ready;
      chk("in_ready", in_ready, e_ready);
      rd_chk = m_valid[ra];
      if (rd_chk) exp_q.push_back(m_mem[ra]);
      e_done = 0; e_ec = 0; e_eo = 0;
      if (clr) begin
         pend_q.delete();
         m_fill = 0;
      end else if (pend_q.size() > 0) begin
         p = pend_q.pop_front();
         m_mem[p.addr] = p.data;
         m_valid[p.addr] = 1;
         m_fill++;
         e_done = p.last;
      end else if (v) begin
         if (cnt == 0 || cnt > MW) e_ec = 1;
         else if (m_fill + cnt > D) e_eo = 1;
         else begin
            for (int k = 0; k < cnt; k++) begin
               p.addr = m_fill + k;
               p.data = w[k*W +: W];
               p.last = (k == cnt - 1);
               pend_q.push_back(p);
            end
         end
      end
      @(posedge clk);
      #1;
      obs_fill = int'(fill); obs_full = full; obs_done = batch_done;
      obs_ec = err_count; obs_eo = err_overflow; obs_rd = rd_data;
      chk("fill", fill, m_fill);
      chk("full", full, m_fill == D);
      chk("batch_done", batch_done, e_done);
      chk("err_count", err_count, e_ec);
      chk("err_overflow", err_overflow, e_eo);
      if (rd_chk) chk("rd_data", rd_data, exp_q.pop_front());
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, '0, 0, 0, $urandom_range(0, D-1));
   endtask

   task automatic send_batch(input logic [MW*W-1:0] w, input int n);
      step(1, w, n, 0, $urandom_range(0, D-1));
      idle(n);
   endtask

   task automatic reset_outputs_chk(input string tag);
      chk({tag, "_fill"}, fill, 0);
      chk({tag, "_full"}, full, 0);
      chk({tag, "_rd_data"}, rd_data, 0);
      chk({tag, "_batch_done"}, batch_done, 0);
      chk({tag, "_err_count"}, err_count, 0);
      chk({tag, "_err_overflow"}, err_overflow, 0);
   endtask

   typedef struct {
      bit v; logic [MW*W-1:0] w; int c; int ra;
      bit e_ready; int e_fill; bit e_done; bit e_ec; bit e_eo;
      bit rd_on; logic [W-1:0] e_rd;
   } vec_t;
   vec_t tbl[8];

   function automatic vec_t mk(bit v, logic [MW*W-1:0] w, int c, int ra, bit er, int ef,
                               bit ed, bit eec, bit eeo, bit rdon, logic [W-1:0] erd);
      vec_t t;
      t.v = v; t.w = w; t.c = c; t.ra = ra; t.e_ready = er; t.e_fill = ef;
      t.e_done = ed; t.e_ec = eec; t.e_eo = eeo; t.rd_on = rdon; t.e_rd = erd;
      return t;
   endfunction

   initial begin
      logic [MW*W-1:0] w1, wa, wb, wc;
      int gap;
      int cnt;

      w1 = '0;
      w1[0 +: W] = 32'hA000_0001;
      w1[W +: W] = 32'hA000_0002;
      tbl[0] = mk(1, w1, 2, 0, 1, 0, 0, 0, 0, 0, '0);
      tbl[1] = mk(0, '0, 0, 0, 0, 1, 0, 0, 0, 0, '0);
      tbl[2] = mk(0, '0, 0, 0, 0, 2, 1, 0, 0, 0, '0);
      tbl[3] = mk(0, '0, 0, 0, 1, 2, 0, 0, 0, 1, 32'hA000_0001);
      tbl[4] = mk(0, '0, 0, 1, 1, 2, 0, 0, 0, 1, 32'hA000_0002);
      tbl[5] = mk(1, rand_words(), 0, 0, 1, 2, 0, 1, 0, 1, 32'hA000_0001);
      tbl[6] = mk(1, rand_words(), 7, 1, 1, 2, 0, 1, 0, 1, 32'hA000_0002);
      tbl[7] = mk(0, '0, 0, 0, 1, 2, 0, 0, 0, 1, 32'hA000_0001);

      for (int i = 0; i < D; i++) m_valid[i] = 0;
      m_fill = 0;
      rst = 1; clear = 0; in_valid = 0; in_words = '0; in_count = '0; rd_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_outputs_chk("reset");
      @(negedge clk);
      rst = 0;

      // constant vector table: first batch, read-back, count errors
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].v, tbl[i].w, tbl[i].c, 0, tbl[i].ra);
         chk("tbl_ready", obs_ready, tbl[i].e_ready);
         chk("tbl_fill", obs_fill, tbl[i].e_fill);
         chk("tbl_done", obs_done, tbl[i].e_done);
         chk("tbl_err_count", obs_ec, tbl[i].e_ec);
         chk("tbl_err_overflow", obs_eo, tbl[i].e_eo);
         if (tbl[i].rd_on) chk("tbl_rd_data", obs_rd, tbl[i].e_rd);
      end

      // back-to-back 6 then 3: second accept lands 7 cycles after the first
      step(0, '0, 0, 1, 0);
      wa = rand_words();
      wb = rand_words();
      step(1, wa, 6, 0, 0);
      gap = 0;
      do begin
         step(1, wb, 3, 0, 0);
         gap++;
      end while (!obs_ready && gap < 20);
      chk("b2b_gap", gap, 7);
      idle(3);
      chk("b2b_fill", obs_fill, 9);
      for (int k = 0; k < 3; k++) begin
         step(0, '0, 0, 0, 6 + k);
         chk("b2b_ram", obs_rd, wb[k*W +: W]);
      end

      // overflow and full
      step(0, '0, 0, 1, 0);
      send_batch(rand_words(), 6);
      send_batch(rand_words(), 6);
      step(1, rand_words(), 5, 0, 0);
      chk("ovf_pulse", obs_eo, 1);
      chk("ovf_fill_hold", obs_fill, 12);
      send_batch(rand_words(), 4);
      chk("full_fill", obs_fill, 16);
      chk("full_flag", obs_full, 1);
      step(1, rand_words(), 1, 0, 0);
      chk("full_reject", obs_eo, 1);

      // clear on the second write cycle of a 5-word batch
      step(0, '0, 0, 1, 0);
      wc = rand_words();
      step(1, wc, 5, 0, 0);
      step(0, '0, 0, 0, 0);
      step(0, '0, 0, 1, 0);
      chk("clr_fill", obs_fill, 0);
      step(0, '0, 0, 0, 1);
      chk("clr_word1_kept_old", obs_rd === wc[W +: W] ? 1'b0 : 1'b1, 1);
      wa = rand_words();
      send_batch(wa, 1);
      step(0, '0, 0, 0, 0);
      chk("clr_overwrite", obs_rd, wa[0 +: W]);

      // asynchronous reset in the middle of a 4-word batch
      step(0, '0, 0, 1, 0);
      wb = rand_words();
      step(1, wb, 4, 0, 0);
      idle(2);
      rst = 1;
      #1;
      reset_outputs_chk("midrst");
      pend_q.delete();
      m_fill = 0;
      @(negedge clk);
      rst = 0;
      for (int k = 0; k < 4; k++) step(0, '0, 0, 0, k);

      // random traffic against the model
      for (int i = 0; i < 700; i++) begin
         if ($urandom_range(0, 9) == 0) cnt = ($urandom_range(0, 1) == 0) ? 0 : 7;
         else cnt = $urandom_range(1, MW);
         step($urandom_range(0, 1), rand_words(), cnt, $urandom_range(0, 39) == 0,
              $urandom_range(0, D-1));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
